// File: rtl/snn_image_loader_if.sv
// Host/core-facing bundle of snn_image_loader: byte stream in, pixel read
// port to the core, start/done handshake and held classification result.
interface snn_image_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [9:0] addr_input_unit;
    logic       q_input;
    logic       start;
    logic       done;
    logic [3:0] digit;
    logic [3:0] res_digit;
    logic       res_valid;
    logic       res_ack;
    logic       busy;
    logic       err;

    modport slave (
        input  rx_data, rx_valid, addr_input_unit, done, digit, res_ack,
        output rx_ready, q_input, start, res_digit, res_valid, busy, err
    );

    modport master (
        output rx_data, rx_valid, addr_input_unit, done, digit, res_ack,
        input  rx_ready, q_input, start, res_digit, res_valid, busy, err
    );
endinterface

// File: rtl/snn_image_loader.sv
// Unpacks a byte stream into a PIX_CNT-bit binary image, serves it to snn_core
// with one-cycle read latency, and sequences start/done/result handoff.
// Optional trailing XOR checksum byte: define SNN_LOADER_CKSUM_EN.
module snn_image_loader #(
    parameter  int PIX_CNT = 784,
    localparam int BYTES   = PIX_CNT / 8
) (
    input logic          clk,
    input logic          rst,
    snn_image_loader_if.slave bus
);

    typedef enum logic [2:0] {
        LOAD   = 3'd0,
        START  = 3'd1,
        RUN    = 3'd2,
`ifdef SNN_LOADER_CKSUM_EN
        CKSUM  = 3'd4,
`endif
        REPORT = 3'd3
    } state_t;

    localparam logic [6:0]  LAST_BYTE = 7'(BYTES - 1);
    localparam logic [10:0] PIX_LIM   = 11'(PIX_CNT);

    state_t             state, state_n;
    logic [6:0]         byte_cnt;
    logic [PIX_CNT-1:0] pix;
    logic [9:0]         wr_base;
    logic               q_reg;
    logic [3:0]         res_reg;
    logic               xfer;
    logic               load_xfer;
    logic               last_byte;

`ifdef SNN_LOADER_CKSUM_EN
    logic [7:0]         csum;
    logic               csum_bad;
    logic               err_reg;
`endif

    assign bus.rx_ready  = (state == LOAD)
`ifdef SNN_LOADER_CKSUM_EN
                        || (state == CKSUM)
`endif
                        ;
    assign bus.start     = (state == START);
    assign bus.busy      = (state == START) || (state == RUN);
    assign bus.res_valid = (state == REPORT);
    assign bus.res_digit = res_reg;
    assign bus.q_input   = q_reg;

    assign xfer      = bus.rx_valid && bus.rx_ready;
    assign load_xfer = xfer && (state == LOAD);
    assign last_byte = (byte_cnt == LAST_BYTE);
    assign wr_base   = {byte_cnt, 3'b000};

`ifdef SNN_LOADER_CKSUM_EN
    assign csum_bad = xfer && (state == CKSUM) && (bus.rx_data != csum);
    assign bus.err  = err_reg;
`else
    assign bus.err  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            LOAD: begin
                if (load_xfer && last_byte) begin
`ifdef SNN_LOADER_CKSUM_EN
                    state_n = CKSUM;
`else
                    state_n = START;
`endif
                end
            end
`ifdef SNN_LOADER_CKSUM_EN
            CKSUM: begin
                if (xfer) state_n = csum_bad ? LOAD : START;
            end
`endif
            START:   state_n = RUN;
            RUN:     if (bus.done)    state_n = REPORT;
            REPORT:  if (bus.res_ack) state_n = LOAD;
            default: state_n = LOAD;
        endcase
    end

    // Reset discards a partial image by restarting the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            byte_cnt <= '0;
        else if (load_xfer)
            byte_cnt <= last_byte ? 7'd0 : byte_cnt + 7'd1;
    end

`ifdef SNN_LOADER_CKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum    <= '0;
            err_reg <= 1'b0;
        end else begin
            if (load_xfer)
                csum <= (byte_cnt == 7'd0) ? bus.rx_data : (csum ^ bus.rx_data);
            err_reg <= csum_bad;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            res_reg <= '0;
        else if (state == RUN && bus.done)
            res_reg <= bus.digit;
    end

    // Pixel store is deliberately not reset; every image rewrites all bits.
    always_ff @(posedge clk) begin
        if (load_xfer)
            pix[wr_base +: 8] <= bus.rx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q_reg <= 1'b0;
        else
            q_reg <= ({1'b0, bus.addr_input_unit} < PIX_LIM) ? pix[bus.addr_input_unit] : 1'b0;
    end

endmodule
